// File: rtl/ofdm_cp_remove_if.sv
// Sample stream bundle for the OFDM cyclic-prefix remover: input samples with
// symbol sync on one side, FFT-bound body samples with framing markers on the other.
interface ofdm_cp_remove_if #(
    parameter int W = 16
);
    logic                di_en;
    logic signed [W-1:0] di_re;
    logic signed [W-1:0] di_im;
    logic                sync;
    logic                do_en;
    logic signed [W-1:0] do_re;
    logic signed [W-1:0] do_im;
    logic                do_first;
    logic                do_last;
    logic                cp_err;

    modport master (
        output di_en, di_re, di_im, sync,
        input  do_en, do_re, do_im, do_first, do_last, cp_err
    );

    modport slave (
        input  di_en, di_re, di_im, sync,
        output do_en, do_re, do_im, do_first, do_last, cp_err
    );
endinterface

// File: rtl/ofdm_cp_remove.sv
// Receive-side cyclic-prefix remover: drops CP_LEN prefix samples and forwards N body
// samples per symbol with first/last markers. Define CP_CHECK_EN to build the prefix check.
module ofdm_cp_remove #(
    parameter int N      = 64,
    parameter int CP_LEN = 16,
    parameter int W      = 16,
    parameter int TOL    = 4
) (
    input  logic             clk,
    input  logic             reset,
    ofdm_cp_remove_if.slave  bus
);
    localparam int TOTAL = CP_LEN + N;
    localparam int IW    = $clog2(TOTAL);

    typedef enum logic {S_CP, S_BODY} state_t;

    state_t              state_reg;
    logic [IW-1:0]       idx_reg;
    logic                do_en_reg;
    logic signed [W-1:0] do_re_reg;
    logic signed [W-1:0] do_im_reg;
    logic                do_first_reg;
    logic                do_last_reg;
    logic                cp_err_reg;

    // A sync sample restarts the symbol, whatever the current position is.
    logic [IW-1:0] cur_idx;
    state_t        cur_state;
    logic [IW-1:0] b_idx;
    logic          is_body;
    logic          is_last;
    logic          err_next;

    always_comb begin
        cur_idx   = bus.sync ? '0 : idx_reg;
        cur_state = bus.sync ? S_CP : state_reg;
        b_idx     = cur_idx - IW'(CP_LEN);
        is_body   = (cur_state == S_BODY);
        is_last   = is_body && (b_idx == IW'(N - 1));
    end

`ifdef CP_CHECK_EN
    logic signed [W-1:0] buf_re [CP_LEN];
    logic signed [W-1:0] buf_im [CP_LEN];
    logic [CP_LEN-1:0]   wr_hit;
    logic [CP_LEN-1:0]   rd_hit;
    logic signed [W-1:0] ref_re;
    logic signed [W-1:0] ref_im;
    logic                cmp_en;
    logic signed [W:0]   d_re;
    logic signed [W:0]   d_im;
    logic                mismatch_now;
    logic                flag_reg;

    localparam logic signed [W:0] TOL_S = (W+1)'(TOL);

    // Prefix slot gi is written by idx=gi and checked against body b=N-CP_LEN+gi.
    generate
        for (genvar gi = 0; gi < CP_LEN; gi++) begin : g_slot
            assign wr_hit[gi] = !is_body && (cur_idx == IW'(gi));
            assign rd_hit[gi] = is_body && (b_idx == IW'(N - CP_LEN + gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < CP_LEN; i++) begin
                buf_re[i] <= '0;
                buf_im[i] <= '0;
            end
        end else if (bus.di_en) begin
            for (int i = 0; i < CP_LEN; i++) begin
                if (wr_hit[i]) begin
                    buf_re[i] <= bus.di_re;
                    buf_im[i] <= bus.di_im;
                end
            end
        end
    end

    always_comb begin
        ref_re = '0;
        ref_im = '0;
        cmp_en = 1'b0;
        for (int i = 0; i < CP_LEN; i++) begin
            if (rd_hit[i]) begin
                ref_re = buf_re[i];
                ref_im = buf_im[i];
                cmp_en = 1'b1;
            end
        end
        // One extra bit so the difference of two extreme samples cannot wrap.
        d_re = {bus.di_re[W-1], bus.di_re} - {ref_re[W-1], ref_re};
        d_im = {bus.di_im[W-1], bus.di_im} - {ref_im[W-1], ref_im};
        mismatch_now = cmp_en && ((d_re > TOL_S) || (d_re < -TOL_S) ||
                                  (d_im > TOL_S) || (d_im < -TOL_S));
        err_next = is_last && (flag_reg || mismatch_now);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flag_reg <= 1'b0;
        end else if (bus.di_en) begin
            if (cur_idx == '0) begin
                flag_reg <= 1'b0;
            end else if (mismatch_now) begin
                flag_reg <= 1'b1;
            end
        end
    end
`else
    assign err_next = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= S_CP;
            idx_reg      <= '0;
            do_en_reg    <= 1'b0;
            do_re_reg    <= '0;
            do_im_reg    <= '0;
            do_first_reg <= 1'b0;
            do_last_reg  <= 1'b0;
            cp_err_reg   <= 1'b0;
        end else begin
            do_en_reg    <= 1'b0;
            do_first_reg <= 1'b0;
            do_last_reg  <= 1'b0;
            cp_err_reg   <= 1'b0;
            if (bus.di_en) begin
                if (!is_body) begin
                    idx_reg   <= cur_idx + IW'(1);
                    state_reg <= (cur_idx == IW'(CP_LEN - 1)) ? S_BODY : S_CP;
                end else begin
                    do_en_reg    <= 1'b1;
                    do_re_reg    <= bus.di_re;
                    do_im_reg    <= bus.di_im;
                    do_first_reg <= (b_idx == '0);
                    do_last_reg  <= is_last;
                    cp_err_reg   <= err_next;
                    if (is_last) begin
                        idx_reg   <= '0;
                        state_reg <= S_CP;
                    end else begin
                        idx_reg   <= cur_idx + IW'(1);
                        state_reg <= S_BODY;
                    end
                end
            end
        end
    end

    assign bus.do_en    = do_en_reg;
    assign bus.do_re    = do_re_reg;
    assign bus.do_im    = do_im_reg;
    assign bus.do_first = do_first_reg;
    assign bus.do_last  = do_last_reg;
    assign bus.cp_err   = cp_err_reg;
endmodule

// File: tb/tb_ofdm_cp_remove.sv
// Bench for ofdm_cp_remove: a symbol-level model predicts every output cycle, plus
// literal per-test expectations on counts and marker positions.
module tb_ofdm_cp_remove;
    localparam int N      = 64;
    localparam int CP_LEN = 16;
    localparam int W      = 16;
    localparam int TOL    = 4;
    localparam int TOTAL  = CP_LEN + N;
`ifdef CP_CHECK_EN
    localparam int CP_ON = 1;
`else
    localparam int CP_ON = 0;
`endif

    logic clk;
    logic reset;
    ofdm_cp_remove_if #(.W(W)) bus ();

    ofdm_cp_remove #(.N(N), .CP_LEN(CP_LEN), .W(W), .TOL(TOL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    // Model: position within the symbol and the symbol's samples so far.
    int pos = 0;
    int sym_re [TOTAL];
    int sym_im [TOTAL];
    logic exp_en = 0, exp_first = 0, exp_last = 0, exp_err = 0;
    int   exp_re = 0, exp_im = 0;

    function automatic logic symbol_mismatch();
        logic bad = 1'b0;
        for (int k = 0; k < CP_LEN; k++) begin
            int dr = sym_re[k + N] - sym_re[k];
            int di = sym_im[k + N] - sym_im[k];
            if (dr > TOL || dr < -TOL || di > TOL || di < -TOL) bad = 1'b1;
        end
        return bad;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            pos = 0;
            exp_en = 0; exp_first = 0; exp_last = 0; exp_err = 0;
            exp_re = 0; exp_im = 0;
        end else begin
            exp_en = 0; exp_first = 0; exp_last = 0; exp_err = 0;
            if (bus.di_en === 1'b1) begin
                if (bus.sync === 1'b1) pos = 0;
                sym_re[pos] = int'(bus.di_re);
                sym_im[pos] = int'(bus.di_im);
                if (pos >= CP_LEN) begin
                    exp_en    = 1;
                    exp_re    = sym_re[pos];
                    exp_im    = sym_im[pos];
                    exp_first = (pos == CP_LEN);
                    exp_last  = (pos == TOTAL - 1);
                    exp_err   = exp_last && (CP_ON != 0) && symbol_mismatch();
                end
                pos = (pos == TOTAL - 1) ? 0 : pos + 1;
            end
        end
    end

    task automatic cmp(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
        end
    endtask

    task automatic check_lit(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Per-test observations of the DUT.
    int n_out = 0, n_first = 0, n_last = 0, n_err = 0;
    int first_re = -1, last_re = -1;

    always @(negedge clk) begin
        cmp("do_en",    W'(bus.do_en),    W'(exp_en));
        cmp("do_re",    bus.do_re,        W'(exp_re));
        cmp("do_im",    bus.do_im,        W'(exp_im));
        cmp("do_first", W'(bus.do_first), W'(exp_first));
        cmp("do_last",  W'(bus.do_last),  W'(exp_last));
        cmp("cp_err",   W'(bus.cp_err),   W'(exp_err));
        if (bus.do_en === 1'b1) begin
            n_out++;
            if (bus.do_first === 1'b1) begin
                n_first++;
                first_re = int'(bus.do_re);
            end
            if (bus.do_last === 1'b1) begin
                n_last++;
                last_re = int'(bus.do_re);
            end
            if (bus.cp_err === 1'b1) n_err++;
        end
    end

    task automatic clear_counts();
        n_out = 0; n_first = 0; n_last = 0; n_err = 0;
        first_re = -1; last_re = -1;
    endtask

    task automatic send(input logic en, input int re, input int im, input logic sy);
        bus.di_en = en;
        bus.di_re = W'(re);
        bus.di_im = W'(im);
        bus.sync  = sy;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int cycles);
        bus.di_en = 1'b0;
        bus.sync  = 1'b0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Symbol whose prefix repeats the body tail, optionally perturbing one sample.
    task automatic send_cp_sym(input int mod_idx, input int d_re, input int d_im);
        int vr [TOTAL];
        int vi [TOTAL];
        for (int b = 0; b < N; b++) begin
            vr[CP_LEN + b] = ((b * 37) % 200) - 100;
            vi[CP_LEN + b] = 50 - b;
        end
        for (int k = 0; k < CP_LEN; k++) begin
            vr[k] = vr[k + N];
            vi[k] = vi[k + N];
        end
        if (mod_idx >= 0) begin
            vr[mod_idx] = vr[mod_idx] + d_re;
            vi[mod_idx] = vi[mod_idx] + d_im;
        end
        for (int k = 0; k < TOTAL; k++) send(1'b1, vr[k], vi[k], 1'b0);
    endtask

    initial begin
        bus.di_en = 1'b0; bus.di_re = '0; bus.di_im = '0; bus.sync = 1'b0;
        reset = 1'b0;

        // Reset held while inputs toggle randomly
        repeat (5) begin
            bus.di_en = 1'($urandom);
            bus.di_re = W'($urandom);
            bus.di_im = W'($urandom);
            bus.sync  = 1'($urandom);
            @(posedge clk);
            #1;
        end
        check_lit("rst_do_en", int'(bus.do_en), 0);
        check_lit("rst_do_re", int'(bus.do_re), 0);
        bus.di_en = 1'b0; bus.sync = 1'b0;
        reset = 1'b1;
        idle(1);
        check_lit("post_rst_do_en", int'(bus.do_en), 0);

        // Basic symbol
        clear_counts();
        for (int k = 0; k < TOTAL; k++) send(1'b1, k, -k, 1'b0);
        idle(3);
        check_lit("basic_n_out", n_out, 64);
        check_lit("basic_first_re", first_re, 16);
        check_lit("basic_last_re", last_re, 79);
        check_lit("basic_n_first", n_first, 1);
        check_lit("basic_n_last", n_last, 1);
        check_lit("basic_n_err", n_err, CP_ON);

        // Gapped input
        clear_counts();
        for (int k = 0; k < TOTAL; k++) begin
            send(1'b1, k, -k, 1'b0);
            send(1'b0, 999, 999, 1'b0);
        end
        idle(3);
        check_lit("gap_n_out", n_out, 64);
        check_lit("gap_first_re", first_re, 16);
        check_lit("gap_last_re", last_re, 79);
        check_lit("gap_n_last", n_last, 1);

        // Resync at body b=30 (idx 46), then a full symbol from the sync sample
        clear_counts();
        for (int k = 0; k < 46; k++) send(1'b1, 500 + k, 0, 1'b0);
        for (int j = 0; j < TOTAL; j++) send(1'b1, 1000 + j, j, (j == 0));
        idle(3);
        check_lit("resync_n_out", n_out, 30 + 64);
        check_lit("resync_n_first", n_first, 2);
        check_lit("resync_n_last", n_last, 1);
        check_lit("resync_first_re", first_re, 1016);
        check_lit("resync_last_re", last_re, 1079);
        check_lit("resync_n_err", n_err, CP_ON);

        // Back-to-back symbols
        clear_counts();
        for (int s = 0; s < 3; s++)
            for (int k = 0; k < TOTAL; k++) send(1'b1, s * 100 + k, k, 1'b0);
        idle(3);
        check_lit("b2b_n_out", n_out, 192);
        check_lit("b2b_n_first", n_first, 3);
        check_lit("b2b_n_last", n_last, 3);
        check_lit("b2b_last_re", last_re, 279);

        // Prefix check: clean, +5 at 70, +4 at 70 (limit), -5 im at 79, +5 at 64
        clear_counts();
        send_cp_sym(-1, 0, 0);
        idle(2);
        check_lit("cp_clean_err", n_err, 0);
        clear_counts();
        send_cp_sym(70, 5, 0);
        idle(2);
        check_lit("cp_70p5_err", n_err, CP_ON);
        check_lit("cp_70p5_last", n_last, 1);
        clear_counts();
        send_cp_sym(70, 4, 0);
        idle(2);
        check_lit("cp_70p4_err", n_err, 0);
        clear_counts();
        send_cp_sym(79, 0, -5);
        idle(2);
        check_lit("cp_79im_err", n_err, CP_ON);
        clear_counts();
        send_cp_sym(64, 5, 0);
        idle(2);
        check_lit("cp_64_err", n_err, CP_ON);

        // Reset asserted mid-body clears outputs at once; counting restarts
        for (int k = 0; k < 30; k++) send(1'b1, 300 + k, 7, 1'b0);
        bus.di_en = 1'b0;
        check_lit("mid_do_en_before", int'(bus.do_en), 1);
        #2;
        reset = 1'b0;
        #1;
        check_lit("mid_rst_do_en", int'(bus.do_en), 0);
        check_lit("mid_rst_do_re", int'(bus.do_re), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        clear_counts();
        for (int k = 0; k < TOTAL; k++) send(1'b1, 2000 + k, -k, 1'b0);
        idle(3);
        check_lit("after_rst_n_out", n_out, 64);
        check_lit("after_rst_first_re", first_re, 2016);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ofdm_cp_remove.md
# ofdm_cp_remove

Receive-side cyclic-prefix remover for the OFDM chain, and the counterpart of the transmit-side CP inserter. It accepts a stream of complex samples organised as symbols of CP_LEN prefix samples followed by N body samples. It discards the prefix and forwards exactly N body samples per symbol to FFT64, with first/last markers. It sits between the IFFT/channel output and the FFT64 input.

## Interface
Parameters:
- N, 64, body samples per symbol (FFT size)
- CP_LEN, 16, prefix samples per symbol; must satisfy 1 ≤ CP_LEN < N
- W, 16, width of each signed I/Q component
- TOL, 4, maximum allowed |difference| per component for the prefix check

Ports:
- clk  input  1  system clock; all logic on posedge
- reset  input  1  asynchronous, active-low reset
- di_en  input  1  input sample valid
- di_re  input  W  input real part, signed
- di_im  input  W  input imaginary part, signed
- sync  input  1  symbol-start marker, sampled only when di_en=1
- do_en  output  1  output sample valid
- do_re  output  W  output real part
- do_im  output  W  output imaginary part
- do_first  output  1  marks body sample 0
- do_last  output  1  marks body sample N-1
- cp_err  output  1  one-cycle prefix-mismatch pulse

## Operation
- Only samples with di_en=1 count. Cycles with di_en=0 are ignored and hold all state.
- Sample counter idx runs 0..CP_LEN+N-1 and wraps to 0 after CP_LEN+N-1.
- Two-state FSM:
  - S_CP: while idx < CP_LEN. Samples are dropped.
  - S_BODY: while idx ≥ CP_LEN. Samples are forwarded with body index b = idx−CP_LEN.
  - S_CP → S_BODY when the sample at idx=CP_LEN−1 is accepted.
  - S_BODY → S_CP when the sample at b=N−1 is accepted.
- sync=1 with di_en=1 forces that sample to be treated as idx=0 (first prefix sample), from any state.
  - If sync arrives mid-body, the partial symbol is abandoned: no do_last and no cp_err for it.
  - Body samples already emitted are not retracted.
- After reset, the FSM is in S_CP with idx=0, so the first valid sample is treated as a prefix sample.
- do_re/do_im hold their last value when do_en=0.

## Timing
- All outputs are registered. Latency is 1 cycle from an accepted body sample to do_en.
- do_en=1 in the cycle after each accepted body sample.
- do_first coincides with the do_en for b=0. do_last coincides with the do_en for b=N−1.
- Output throughput equals input throughput. There is no backpressure.
- cp_err, when asserted, is high for one cycle coinciding with do_last.
- Reset values: do_en=0, do_re=0, do_im=0, do_first=0, do_last=0, cp_err=0; FSM=S_CP, idx=0, prefix buffer and mismatch flag cleared.
- If reset is asserted mid-symbol, all outputs go to 0 immediately (asynchronous). After release, counting restarts at idx=0.

## Configuration
- Macro `CP_CHECK_EN`.
- Defined:
  - Prefix samples 0..CP_LEN−1 are stored in a CP_LEN-deep buffer.
  - Body samples b = N−CP_LEN..N−1 are compared with buffer entry b−(N−CP_LEN).
  - Differences are computed at W+1 bits.
  - A sticky mismatch flag is set if |Δre| > TOL or |Δim| > TOL for any compared pair. The comparison for b=N−1 is included.
  - cp_err pulses with do_last if the flag is set. The flag clears at the next idx=0.
- Undefined: no buffer or comparators are built, and cp_err is tied to 0.

## Test plan
- Reset: hold reset=0 while driving random di_* → all outputs 0. Release, then one idle cycle → do_en stays 0.
- Basic symbol: 80 consecutive samples with di_re=k, di_im=−k (k=0..79) → 64 do_en pulses carrying do_re=16..79. do_first accompanies 16, do_last accompanies 79, each 1 cycle after input. Samples 0..15 are never output.
- Gapped input: the same 80 samples with di_en toggling 1,0,1,0… → identical output sequence, and each do_en is exactly 1 cycle after its accepted input.
- Resync: sync on the sample at b=30, then a full 80-sample symbol → no do_last for the aborted symbol, and the next do_first arrives with the 17th sample after sync.
- Back-to-back wrap: 3 symbols streamed continuously → 192 outputs and exactly 3 do_first/do_last pairs, with no dropped or extra samples.
- CP check (CP_CHECK_EN): symbol where sample k equals sample k+64 → cp_err=0. Then sample 70 re offset by +5 (TOL=4) → cp_err=1 together with do_last. Macro undefined → cp_err=0 in both cases.
